// File: rtl/text_link_ctrl_if.sv
// Handshake and status bundle between a text_link_ctrl and its driver.
// The master modport drives requests and init status; slave is the controller side.
interface text_link_ctrl_if;
  logic       start;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       crypt_rst;
  logic [7:0] key;
  logic       enc_init_done;
  logic       dec_init_done;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       sink_valid;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] byte_count;

  modport master (
    output start, src_valid, src_data, enc_init_done, dec_init_done,
    input  src_ready, crypt_rst, key, tx_valid, tx_data, sink_valid, busy, done, error,
           byte_count
  );

  modport slave (
    input  start, src_valid, src_data, enc_init_done, dec_init_done,
    output src_ready, crypt_rst, key, tx_valid, tx_data, sink_valid, busy, done, error,
           byte_count
  );
endinterface

// File: rtl/text_link_ctrl.sv
// Sequences key load, encryptor/decryptor init and byte streaming of one message.
// Define TEXT_LINK_CTRL_INIT_TMO_EN to add a watchdog on the init wait.
module text_link_ctrl #(
  parameter logic [7:0]  KEY      = 8'd123,
  parameter int unsigned PIPE_LAT = 4,
  parameter int unsigned MSG_MAX  = 255,
  parameter int unsigned INIT_TMO = 1023
) (
  input logic             clk,
  input logic             reset,
  text_link_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    StIdle, StKeyLoad, StWaitInit, StStream, StDrain, StDone, StErr
  } state_e;

  localparam logic [7:0] MsgMax = 8'(MSG_MAX);

  state_e              r_state;
  logic                r_kl_cnt;
  logic [PIPE_LAT-1:0] r_pipe;
  logic                r_tx_valid;
  logic [7:0]          r_tx_data;
  logic                r_crypt_rst;
  logic [7:0]          r_key;
  logic                r_busy;
  logic                r_done;
  logic                r_error;
  logic [7:0]          r_count;

  logic w_init_ok;
  logic w_src_ready;
  logic w_xfer;
  logic w_empty;
  logic w_last;
  logic w_tmo_hit;

  assign w_init_ok   = bus.enc_init_done & bus.dec_init_done;
  // Losing init status blocks the transfer in the same cycle it is seen.
  assign w_src_ready = (r_state == StStream) & w_init_ok & (r_count < MsgMax);
  assign w_xfer      = w_src_ready & bus.src_valid;
  assign w_empty     = ~r_tx_valid & ~(|r_pipe);
  assign w_last      = (bus.src_data == 8'h00) | ((r_count + 8'd1) == MsgMax);

`ifdef TEXT_LINK_CTRL_INIT_TMO_EN
  logic [9:0] r_tmo;
  assign w_tmo_hit = (r_tmo == 10'(INIT_TMO - 1));
`else
  assign w_tmo_hit = 1'b0;
`endif

  // Valid-only model of the cipher pipeline; data is not tracked here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= r_tx_valid;
      for (int i = 1; i < PIPE_LAT; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= StIdle;
      r_kl_cnt    <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= 8'h00;
      r_crypt_rst <= 1'b1;
      r_key       <= 8'h00;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
      r_count     <= 8'h00;
`ifdef TEXT_LINK_CTRL_INIT_TMO_EN
      r_tmo       <= '0;
`endif
    end else begin
      r_tx_valid <= 1'b0;
      r_done     <= 1'b0;
      unique case (r_state)
        StIdle, StErr: begin
          if (bus.start) begin
            r_state     <= StKeyLoad;
            r_kl_cnt    <= 1'b0;
            r_crypt_rst <= 1'b1;
            r_key       <= KEY;
            r_busy      <= 1'b1;
            r_count     <= 8'h00;
          end
        end
        StKeyLoad: begin
          r_kl_cnt <= 1'b1;
          if (r_kl_cnt) begin
            r_state     <= StWaitInit;
            r_crypt_rst <= 1'b0;
`ifdef TEXT_LINK_CTRL_INIT_TMO_EN
            r_tmo       <= '0;
`endif
          end
        end
        StWaitInit: begin
          if (w_init_ok) begin
            r_state <= StStream;
          end else if (w_tmo_hit) begin
            r_state     <= StErr;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
            r_crypt_rst <= 1'b1;
          end
`ifdef TEXT_LINK_CTRL_INIT_TMO_EN
          if (!w_init_ok) begin
            r_tmo <= r_tmo + 10'd1;
          end
`endif
        end
        StStream: begin
          if (!w_init_ok) begin
            r_state     <= StErr;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
            r_crypt_rst <= 1'b1;
          end else if (w_xfer) begin
            r_tx_valid <= 1'b1;
            r_tx_data  <= bus.src_data;
            r_count    <= r_count + 8'd1;
            if (w_last) begin
              r_state <= StDrain;
            end
          end
        end
        StDrain: begin
          if (!w_init_ok) begin
            r_state     <= StErr;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
            r_crypt_rst <= 1'b1;
          end else if (w_empty) begin
            r_state <= StDone;
            r_done  <= 1'b1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.src_ready  = w_src_ready;
  assign bus.crypt_rst  = r_crypt_rst;
  assign bus.key        = r_key;
  assign bus.tx_valid   = r_tx_valid;
  assign bus.tx_data    = r_tx_data;
  assign bus.sink_valid = r_pipe[PIPE_LAT-1];
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.error      = r_error;
  assign bus.byte_count = r_count;

endmodule

// File: tb/tb_text_link_ctrl.sv
// Randomized self-checking bench for text_link_ctrl against a message-level model.
// Honours TEXT_LINK_CTRL_INIT_TMO_EN for the watchdog expectations.
module tb_text_link_ctrl;
  localparam logic [7:0]  Key     = 8'd123;
  localparam int unsigned PipeLat = 4;
  localparam int unsigned MsgMax  = 4;
  localparam int unsigned InitTmo = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  text_link_ctrl_if bus ();

  text_link_ctrl #(
    .KEY     (Key),
    .PIPE_LAT(PipeLat),
    .MSG_MAX (MsgMax),
    .INIT_TMO(InitTmo)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_errs   = 0;

  // Event log filled on the falling edge, away from the active edge.
  int         cyc = 0;
  int         n_done = 0;
  logic [7:0] q_tx[$];
  int         q_txt[$];
  int         q_snk[$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (bus.tx_valid) begin
      q_tx.push_back(bus.tx_data);
      q_txt.push_back(cyc);
    end
    if (bus.sink_valid) q_snk.push_back(cyc);
    if (bus.done) n_done <= n_done + 1;
  end

  logic [7:0] msg[$];
  logic [7:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Bytes the link should launch: in order, through the terminator or until MsgMax.
  function automatic void build_expect();
    exp_q.delete();
    foreach (msg[i]) begin
      if (exp_q.size() == int'(MsgMax)) break;
      exp_q.push_back(msg[i]);
      if (msg[i] == 8'h00) break;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic clear_log();
    q_tx.delete();
    q_txt.delete();
    q_snk.delete();
  endtask

  task automatic check_reset_vals();
    check_eq("rst_src_ready",  32'(bus.src_ready),  32'd0);
    check_eq("rst_tx_valid",   32'(bus.tx_valid),   32'd0);
    check_eq("rst_tx_data",    32'(bus.tx_data),    32'd0);
    check_eq("rst_sink_valid", 32'(bus.sink_valid), 32'd0);
    check_eq("rst_crypt_rst",  32'(bus.crypt_rst),  32'd1);
    check_eq("rst_key",        32'(bus.key),        32'd0);
    check_eq("rst_busy",       32'(bus.busy),       32'd0);
    check_eq("rst_done",       32'(bus.done),       32'd0);
    check_eq("rst_error",      32'(bus.error),      32'd0);
    check_eq("rst_byte_count", 32'(bus.byte_count), 32'd0);
  endtask

  // Starts a message and checks the key-load window; returns in WAIT_INIT.
  task automatic start_and_keyload();
    pulse_start();
    @(negedge clk);
    check_eq("kl_crypt_rst1", 32'(bus.crypt_rst), 32'd1);
    check_eq("kl_key",        32'(bus.key),       32'(Key));
    check_eq("kl_busy",       32'(bus.busy),      32'd1);
    @(negedge clk);
    check_eq("kl_crypt_rst2", 32'(bus.crypt_rst), 32'd1);
    @(negedge clk);
    check_eq("wi_crypt_rst",  32'(bus.crypt_rst), 32'd0);
  endtask

  // vmode: 0 valid always, 1 valid every other cycle, 2 random valid.
  task automatic run_msg(input int init_dly, input int vmode);
    int idx;
    int budget;
    int done0;
    bit hs;
    clear_log();
    build_expect();
    done0 = n_done;
    bus.enc_init_done = 1'b0;
    bus.dec_init_done = 1'b0;
    start_and_keyload();
    tick();
    repeat (init_dly) tick();
    bus.enc_init_done = 1'b1;
    bus.dec_init_done = 1'b1;
    idx = 0;
    budget = 0;
    while (n_done == done0 && budget < 200) begin
      case (vmode)
        0:       bus.src_valid = (idx < msg.size());
        1:       bus.src_valid = (idx < msg.size()) && budget[0];
        default: bus.src_valid = (idx < msg.size()) && ($urandom_range(0, 1) == 1);
      endcase
      bus.src_data = (idx < msg.size()) ? msg[idx] : 8'h00;
      @(negedge clk);
      #1;
      hs = bus.src_valid && bus.src_ready;
      tick();
      if (hs) idx++;
      budget++;
    end
    bus.src_valid = 1'b0;
    repeat (PipeLat + 4) tick();
    check_eq("done_pulses", 32'(n_done - done0),   32'd1);
    check_eq("tx_count",    32'(q_tx.size()),      32'(exp_q.size()));
    check_eq("sink_count",  32'(q_snk.size()),     32'(exp_q.size()));
    foreach (exp_q[i]) begin
      if (i < q_tx.size()) check_eq("tx_byte", 32'(q_tx[i]), 32'(exp_q[i]));
      if (i < q_snk.size() && i < q_txt.size())
        check_eq("sink_lat", 32'(q_snk[i] - q_txt[i]), 32'(PipeLat));
    end
    check_eq("byte_count",   32'(bus.byte_count), 32'(exp_q.size()));
    check_eq("end_busy",     32'(bus.busy),       32'd0);
    check_eq("end_src_rdy",  32'(bus.src_ready),  32'd0);
    bus.enc_init_done = 1'b0;
    bus.dec_init_done = 1'b0;
  endtask

  // Streams msg with valid held high until n bytes have been launched.
  task automatic stream_until(input int n);
    int idx;
    int budget;
    bit hs;
    idx = 0;
    budget = 0;
    while (q_tx.size() < n && budget < 50) begin
      bus.src_valid = (idx < msg.size());
      bus.src_data  = (idx < msg.size()) ? msg[idx] : 8'h00;
      @(negedge clk);
      #1;
      hs = bus.src_valid && bus.src_ready;
      tick();
      if (hs) idx++;
      budget++;
    end
    bus.src_valid = 1'b0;
    check_eq("stream_reached", 32'(q_tx.size() >= n), 32'd1);
  endtask

  initial begin
    int len;
    int done0;
    reset = 1'b1;
    bus.start = 1'b0;
    bus.src_valid = 1'b0;
    bus.src_data = 8'h00;
    bus.enc_init_done = 1'b0;
    bus.dec_init_done = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_eq("idle_crypt_rst", 32'(bus.crypt_rst), 32'd1);
    check_eq("idle_src_ready", 32'(bus.src_ready), 32'd0);

    // "HI" plus terminator, valid held high.
    msg = '{8'h48, 8'h49, 8'h00};
    run_msg(3, 0);

    // Six nonzero bytes must be cut at MsgMax.
    msg = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_msg(1, 0);

    // Every-other-cycle valid.
    msg = '{8'h31, 8'h32, 8'h33, 8'h00};
    run_msg(2, 1);

    for (int n = 0; n < 20; n++) begin
      msg.delete();
      len = $urandom_range(1, 6);
      for (int i = 0; i < len; i++) msg.push_back(8'($urandom_range(1, 255)));
      if (len < int'(MsgMax) || $urandom_range(0, 1) == 1) msg[$urandom_range(0, len - 1)] = 8'h00;
      run_msg($urandom_range(0, 5), $urandom_range(0, 2));
    end

    // Init status lost mid-stream.
    msg = '{8'h11, 8'h22, 8'h33, 8'h44};
    clear_log();
    start_and_keyload();
    tick();
    bus.enc_init_done = 1'b1;
    bus.dec_init_done = 1'b1;
    stream_until(2);
    bus.dec_init_done = 1'b0;
    @(negedge clk);
    #1;
    check_eq("drop_src_ready", 32'(bus.src_ready), 32'd0);
    tick();
    @(negedge clk);
    check_eq("err_error",     32'(bus.error),     32'd1);
    check_eq("err_crypt_rst", 32'(bus.crypt_rst), 32'd1);
    check_eq("err_busy",      32'(bus.busy),      32'd0);
    check_eq("err_src_ready", 32'(bus.src_ready), 32'd0);
    tick();
    repeat (PipeLat + 2) tick();
    check_eq("err_sink_drain", 32'(q_snk.size()), 32'(q_tx.size()));
    foreach (q_tx[i]) check_eq("err_tx_byte", 32'(q_tx[i]), 32'(msg[i]));
    pulse_start();
    @(negedge clk);
    check_eq("restart_error",     32'(bus.error),     32'd1);
    check_eq("restart_busy",      32'(bus.busy),      32'd1);
    check_eq("restart_crypt_rst", 32'(bus.crypt_rst), 32'd1);
    tick();
    bus.enc_init_done = 1'b0;
    do_reset();
    check_eq("post_rst_error", 32'(bus.error), 32'd0);

    // Init watchdog: enc never comes up.
    bus.enc_init_done = 1'b0;
    bus.dec_init_done = 1'b1;
    pulse_start();
    repeat (3) @(negedge clk);
    repeat (InitTmo - 1) @(negedge clk);
`ifdef TEXT_LINK_CTRL_INIT_TMO_EN
    check_eq("wd_error_early", 32'(bus.error), 32'd0);
    @(negedge clk);
    check_eq("wd_error",     32'(bus.error),     32'd1);
    check_eq("wd_busy",      32'(bus.busy),      32'd0);
    check_eq("wd_crypt_rst", 32'(bus.crypt_rst), 32'd1);
`else
    repeat (30) @(negedge clk);
    check_eq("wd_off_error", 32'(bus.error), 32'd0);
    check_eq("wd_off_busy",  32'(bus.busy),  32'd1);
`endif
    tick();
    bus.dec_init_done = 1'b0;
    do_reset();

    // Reset while two bytes are still in the pipeline.
    msg = '{8'h41, 8'h00};
    clear_log();
    done0 = n_done;
    start_and_keyload();
    tick();
    bus.enc_init_done = 1'b1;
    bus.dec_init_done = 1'b1;
    stream_until(2);
    check_eq("drain_busy", 32'(bus.busy), 32'd1);
    q_snk.delete();
    @(negedge clk);
    #1;
    reset = 1'b1;
    #1;
    check_reset_vals();
    tick();
    tick();
    reset = 1'b0;
    repeat (PipeLat + 6) tick();
    check_eq("rst_drain_sinks", 32'(q_snk.size()),   32'd0);
    check_eq("rst_drain_done",  32'(n_done - done0), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/text_link_ctrl.md
TEXT_LINK_CTRL -- requirements
Module: text_link_ctrl

Interface
REQ-001 SHALL have parameter KEY, default 123: 8-bit key driven to encryptor and decryptor.
REQ-002 SHALL have parameter PIPE_LAT, default 4: cycles from byte launch into encryptor to decrypted byte valid at sink (range 1..15).
REQ-003 SHALL have parameter MSG_MAX, default 255: maximum bytes per message (range 1..255).
REQ-004 SHALL have parameter INIT_TMO, default 1023: watchdog limit in cycles, range 1..1023 (used only with REQ-028).
REQ-005 SHALL have ports: clk input 1 (system clock, rising edge); reset input 1 (asynchronous, active-high).
REQ-006 SHALL have ports: start input 1 (one-cycle request to send a message); src_valid input 1; src_data input 8; src_ready output 1.
REQ-007 SHALL have ports: crypt_rst output 1 (holds encryptor/decryptor in reset); key output 8; enc_init_done input 1; dec_init_done input 1.
REQ-008 SHALL have ports: tx_valid output 1 and tx_data output 8 (byte launched into encryptor); sink_valid output 1 (decrypted byte valid at sink this cycle).
REQ-009 SHALL have ports: busy output 1; done output 1 (one-cycle pulse); error output 1 (sticky); byte_count output 8.

Function
REQ-010 SHALL implement states IDLE, KEYLOAD, WAIT_INIT, STREAM, DRAIN, DONE, ERR.
REQ-011 IDLE: start=1 -> KEYLOAD, clear byte_count; start in any other state SHALL be ignored.
REQ-012 KEYLOAD: crypt_rst=1 for exactly 2 cycles, key=KEY held constant from KEYLOAD onward; then -> WAIT_INIT.
REQ-013 WAIT_INIT: stay until enc_init_done=1 and dec_init_done=1 in the same cycle, then -> STREAM next cycle.
REQ-014 STREAM: src_ready=1 combinationally; transfer occurs when src_valid=1 and src_ready=1.
REQ-015 On transfer: tx_valid=1 and tx_data=src_data registered, appearing the cycle after the transfer; byte_count increments by 1.
REQ-016 Transfer of src_data=0x00 (terminator) SHALL be launched like any byte, counted, then -> DRAIN.
REQ-017 Transfer making byte_count equal MSG_MAX SHALL -> DRAIN; src_ready SHALL be 0 from that next cycle.
REQ-018 sink_valid SHALL equal tx_valid delayed by exactly PIPE_LAT cycles via a PIPE_LAT-deep valid shift register.
REQ-019 DRAIN: src_ready=0; stay until shift register is empty, then -> DONE.
REQ-020 DONE: done=1 for one cycle, then -> IDLE; byte_count SHALL hold its value until the next accepted start.
REQ-021 busy SHALL be 1 in every state except IDLE and ERR.
REQ-022 byte_count SHALL never wrap; no transfer accepted once equal to MSG_MAX.
REQ-023 enc_init_done or dec_init_done falling to 0 during STREAM or DRAIN SHALL -> ERR, set error, drop src_ready; in-flight sink_valid bits SHALL still shift out.
REQ-024 ERR: crypt_rst=1; leave only by start=1 -> KEYLOAD; error SHALL clear only on reset.

Reset
REQ-025 While reset=1 asynchronously: state=IDLE, src_ready=0, tx_valid=0, tx_data=0x00, sink_valid=0, shift register cleared, crypt_rst=1, key=0x00, busy=0, done=0, error=0, byte_count=0.
REQ-026 Reset asserted mid-message SHALL discard all in-flight bytes without a done pulse.
REQ-027 After reset release, crypt_rst SHALL remain 1 until KEYLOAD completes.

Configuration
REQ-028 Macro TEXT_LINK_CTRL_INIT_TMO_EN defined: a counter SHALL run in WAIT_INIT; reaching INIT_TMO cycles without both init_done -> ERR, set error.
REQ-029 Macro undefined: no watchdog counter; WAIT_INIT SHALL wait indefinitely.

Verification
REQ-030 Reset, start, init_done both high 3 cycles after KEYLOAD, send "HI",0x00 -> tx_valid 3 cycles, sink_valid 3 cycles each delayed 4, done once, byte_count=3.
REQ-031 MSG_MAX=4, source streams 6 nonzero bytes -> exactly 4 accepted, src_ready=0 after 4th, done, byte_count=4.
REQ-032 src_valid toggling every other cycle -> only handshaked bytes launched, order preserved, no duplicate tx_valid.
REQ-033 Drop dec_init_done mid-STREAM -> ERR, error=1, crypt_rst=1, pending sink_valid bits still emerge; start -> KEYLOAD, error still 1.
REQ-034 Assert reset during DRAIN with 2 bytes in flight -> all outputs at reset values immediately, no sink_valid, no done.
REQ-035 With TEXT_LINK_CTRL_INIT_TMO_EN, INIT_TMO=10, enc_init_done held 0 -> error=1 exactly 10 cycles after entering WAIT_INIT; without macro, busy stays 1 and error stays 0.
